// File: rtl/cond_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : cond_resolve_stage
// Purpose  : Resolves conditional branches against the static prediction,
//            applies nullify-next semantics and issues fetch redirects.
// Revision : 1.0 - initial release
// ============================================================================
module cond_resolve_stage #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic              cond_y,
   input  logic              pred_taken,
   input  logic [WORD_W-1:0] in_pc,
   input  logic [WORD_W-1:0] in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_pc,
   output logic              out_nullified,
   output logic              redirect_valid,
   output logic [WORD_W-1:0] redirect_pc,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   typedef enum logic [0:0] {
      S_IDLE      = 1'b0,
      S_NULL_PEND = 1'b1
   } state_t;

   localparam logic [1:0] c_KIND_COND = 2'd1;
   localparam logic [1:0] c_KIND_NULL = 2'd2;
   localparam logic [1:0] c_KIND_JUMP = 2'd3;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_out_valid;
   logic [WORD_W-1:0]   r_out_pc;
   logic                r_out_nullified;
   logic                r_redirect_valid;
   logic [WORD_W-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_accept;
   logic                w_live;
   logic                w_nullify;
   logic                w_taken;
   logic                w_mispredict;
   logic                w_redirect;
   logic [WORD_W-1:0]   w_redirect_pc;

   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   // Anything accepted while the redirect pulse is high is wrong-path.
   assign w_live    = w_accept && !r_redirect_valid;
   assign w_nullify = (r_state == S_NULL_PEND);

   always_comb begin
      w_taken      = 1'b0;
      w_mispredict = 1'b0;
      case (in_kind)
         c_KIND_COND: begin
            w_taken      = cond_y;
            w_mispredict = (cond_y != pred_taken);
         end
         c_KIND_JUMP: begin
            w_taken      = 1'b1;
            w_mispredict = !pred_taken;
         end
         default: ;
      endcase
   end

   assign w_redirect    = w_live && !w_nullify && w_mispredict;
   assign w_redirect_pc = w_taken ? in_target : (in_pc + WORD_W'(4));

   always_comb begin
      w_state_nxt = r_state;
      if (w_live) begin
         if (r_state == S_NULL_PEND)
            w_state_nxt = S_IDLE;
         else if (in_kind == c_KIND_NULL && cond_y)
            w_state_nxt = S_NULL_PEND;
         else
            w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid      <= 1'b0;
         r_out_pc         <= '0;
         r_out_nullified  <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_cnt            <= '0;
      end else begin
         r_redirect_valid <= w_redirect;
         if (w_live) begin
            r_out_valid     <= 1'b1;
            r_out_pc        <= in_pc;
            r_out_nullified <= w_nullify;
         end else if (out_ready) begin
            r_out_valid     <= 1'b0;
         end
         if (w_redirect) begin
            r_redirect_pc <= w_redirect_pc;
            if (r_cnt != {CNT_W{1'b1}})
               r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_pc         = r_out_pc;
   assign out_nullified  = r_out_nullified;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign mispredict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_resolve_stage
// Purpose  : Directed self-checking bench for cond_resolve_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_resolve_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic        cond_y;
   logic        pred_taken;
   logic [31:0] in_pc;
   logic [31:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic        out_nullified;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [15:0] mispredict_cnt;

   // Narrow-counter copy fed the same stimulus, so saturation is reachable quickly.
   logic        sm_in_ready;
   logic        sm_out_valid;
   logic [31:0] sm_out_pc;
   logic        sm_out_nullified;
   logic        sm_redirect_valid;
   logic [31:0] sm_redirect_pc;
   logic [3:0]  sm_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cond_resolve_stage #(.WORD_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .cond_y(cond_y), .pred_taken(pred_taken),
      .in_pc(in_pc), .in_target(in_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_nullified(out_nullified),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mispredict_cnt(mispredict_cnt)
   );

   cond_resolve_stage #(.WORD_W(32), .CNT_W(4)) dut_sm (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sm_in_ready),
      .in_kind(in_kind), .cond_y(cond_y), .pred_taken(pred_taken),
      .in_pc(in_pc), .in_target(in_target), .out_valid(sm_out_valid),
      .out_ready(out_ready), .out_pc(sm_out_pc), .out_nullified(sm_out_nullified),
      .redirect_valid(sm_redirect_valid), .redirect_pc(sm_redirect_pc),
      .mispredict_cnt(sm_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] kind, input logic y, input logic p,
                        input logic [31:0] pc, input logic [31:0] tgt);
      in_valid   = 1'b1;
      in_kind    = kind;
      cond_y     = y;
      pred_taken = p;
      in_pc      = pc;
      in_target  = tgt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_kind = 2'd0; cond_y = 1'b0; pred_taken = 1'b0; in_pc = '0; in_target = '0;
      step(); step();
      total++;
      if ({out_valid, out_nullified, redirect_valid} !== 3'b000 || out_pc !== 32'h0 ||
          redirect_pc !== 32'h0 || mispredict_cnt !== 16'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset: v=%0b pc=%h n=%0b rv=%0b rpc=%h cnt=%0d rdy=%0b required all 0, rdy=1",
                  out_valid, out_pc, out_nullified, redirect_valid, redirect_pc, mispredict_cnt, in_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_plain();
      drive(2'd0, 1'b0, 1'b0, 32'h100, 32'h0);
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_nullified !== 1'b0 || redirect_valid !== 1'b0) begin
         bad++;
         $display("FAIL plain: v=%0b pc=%h n=%0b rv=%0b required 1 100 0 0",
                  out_valid, out_pc, out_nullified, redirect_valid);
      end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL plain_drain: out_valid=%0b required 0", out_valid);
      end
   endtask

   task automatic test_cond_mispredict();
      drive(2'd1, 1'b1, 1'b0, 32'h200, 32'h80);
      step();
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || mispredict_cnt !== 16'd1 ||
          out_valid !== 1'b1 || out_pc !== 32'h200) begin
         bad++;
         $display("FAIL cond_taken_mp: rv=%0b rpc=%h cnt=%0d v=%0b pc=%h required 1 80 1 1 200",
                  redirect_valid, redirect_pc, mispredict_cnt, out_valid, out_pc);
      end
      drive(2'd0, 1'b0, 1'b0, 32'h204, 32'h0);
      step();
      total++;
      if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || mispredict_cnt !== 16'd1) begin
         bad++;
         $display("FAIL flush: v=%0b rv=%0b cnt=%0d required 0 0 1", out_valid, redirect_valid, mispredict_cnt);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_wrap_and_correct();
      drive(2'd1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h40);
      step();
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || mispredict_cnt !== 16'd2) begin
         bad++;
         $display("FAIL wrap: rv=%0b rpc=%h cnt=%0d required 1 00000000 2", redirect_valid, redirect_pc, mispredict_cnt);
      end
      in_valid = 1'b0;
      step();
      drive(2'd1, 1'b1, 1'b1, 32'h10, 32'h50);
      step();
      total++;
      if (redirect_valid !== 1'b0 || mispredict_cnt !== 16'd2 || out_valid !== 1'b1 || out_pc !== 32'h10) begin
         bad++;
         $display("FAIL correct_pred: rv=%0b cnt=%0d v=%0b pc=%h required 0 2 1 10",
                  redirect_valid, mispredict_cnt, out_valid, out_pc);
      end
      drive(2'd3, 1'b0, 1'b0, 32'h20, 32'h600);
      step();
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600 || mispredict_cnt !== 16'd3) begin
         bad++;
         $display("FAIL jump_mp: rv=%0b rpc=%h cnt=%0d required 1 600 3", redirect_valid, redirect_pc, mispredict_cnt);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_nullify();
      drive(2'd2, 1'b1, 1'b0, 32'h300, 32'h0);
      step();
      total++;
      if (out_pc !== 32'h300 || out_nullified !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL null_test_instr: pc=%h n=%0b v=%0b required 300 0 1", out_pc, out_nullified, out_valid);
      end
      drive(2'd3, 1'b0, 1'b0, 32'h304, 32'h900);
      step();
      total++;
      if (out_pc !== 32'h304 || out_nullified !== 1'b1 || redirect_valid !== 1'b0 || mispredict_cnt !== 16'd3) begin
         bad++;
         $display("FAIL nullified: pc=%h n=%0b rv=%0b cnt=%0d required 304 1 0 3",
                  out_pc, out_nullified, redirect_valid, mispredict_cnt);
      end
      drive(2'd0, 1'b0, 1'b0, 32'h308, 32'h0);
      step();
      total++;
      if (out_pc !== 32'h308 || out_nullified !== 1'b0) begin
         bad++;
         $display("FAIL after_null: pc=%h n=%0b required 308 0", out_pc, out_nullified);
      end
      drive(2'd2, 1'b0, 1'b0, 32'h30C, 32'h0);
      step();
      drive(2'd0, 1'b0, 1'b0, 32'h310, 32'h0);
      step();
      total++;
      if (out_pc !== 32'h310 || out_nullified !== 1'b0) begin
         bad++;
         $display("FAIL null_false: pc=%h n=%0b required 310 0", out_pc, out_nullified);
      end
      drive(2'd2, 1'b1, 1'b0, 32'h320, 32'h0);
      step();
      in_valid = 1'b0;
      step(); step();
      drive(2'd1, 1'b1, 1'b0, 32'h324, 32'hA00);
      step();
      total++;
      if (out_pc !== 32'h324 || out_nullified !== 1'b1 || redirect_valid !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL null_persist: pc=%h n=%0b rv=%0b v=%0b required 324 1 0 1",
                  out_pc, out_nullified, redirect_valid, out_valid);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(2'd1, 1'b1, 1'b0, 32'h400, 32'h700);
      step();
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h700 || mispredict_cnt !== 16'd4 ||
          out_pc !== 32'h400 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_first: rv=%0b rpc=%h cnt=%0d pc=%h rdy=%0b required 1 700 4 400 0",
                  redirect_valid, redirect_pc, mispredict_cnt, out_pc, in_ready);
      end
      drive(2'd0, 1'b0, 1'b0, 32'h404, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (redirect_valid !== 1'b0 || out_pc !== 32'h400 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: rv=%0b pc=%h v=%0b rdy=%0b required 0 400 1 0",
                     i, redirect_valid, out_pc, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h404 || mispredict_cnt !== 16'd4) begin
         bad++;
         $display("FAIL bp_release: v=%0b pc=%h cnt=%0d required 1 404 4", out_valid, out_pc, mispredict_cnt);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_saturation();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(2'd3, 1'b0, 1'b0, 32'h1000 + 32'(i * 8), 32'h2000);
         step();
         if (i == 14 || i == 15) begin
            total++;
            if (sm_cnt !== 4'hF || sm_redirect_valid !== 1'b1) begin
               bad++;
               $display("FAIL sat_%0d: cnt=%0d rv=%0b required 15 1", i + 1, sm_cnt, sm_redirect_valid);
            end
         end
         in_valid = 1'b0;
         step();
      end
      total++;
      if (sm_cnt !== 4'hF || mispredict_cnt !== 16'd20) begin
         bad++;
         $display("FAIL sat_final: small=%0d wide=%0d required 15 20", sm_cnt, mispredict_cnt);
      end
   endtask

   task automatic test_reset_midop();
      drive(2'd2, 1'b1, 1'b0, 32'h500, 32'h0);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || mispredict_cnt !== 16'd0 || sm_cnt !== 4'd0) begin
         bad++;
         $display("FAIL rst_midop: v=%0b cnt=%0d small=%0d required 0 0 0", out_valid, mispredict_cnt, sm_cnt);
      end
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(2'd0, 1'b0, 1'b0, 32'h504, 32'h0);
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h504 || out_nullified !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_null: v=%0b pc=%h n=%0b required 1 504 0", out_valid, out_pc, out_nullified);
      end
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_plain();
      test_cond_mispredict();
      test_wrap_and_correct();
      test_nullify();
      test_backpressure();
      test_saturation();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cond_resolve_stage.md
Name: cond_resolve_stage

Overview:
Pipeline stage directly downstream of TestCondUnit. It consumes the 1-bit condition result `y` and resolves conditional branches against the static prediction. It also applies "nullify next instruction" semantics and issues a one-cycle fetch redirect on mispredict. Single registered stage with valid/ready handshake, sitting between the execute-side condition test and the retire/writeback stage.

Parameters:
WORD_W, 32, width of PC and target fields
CNT_W, 16, width of saturating mispredict counter

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; = !out_valid || out_ready
in_kind  in  2  0=plain, 1=cond branch, 2=nullify-next test, 3=unconditional branch
cond_y  in  1  TestCondUnit result for this instruction
pred_taken  in  1  static prediction used at fetch
in_pc  in  WORD_W  instruction address (word aligned)
in_target  in  WORD_W  branch target address
out_valid  out  1  downstream instruction valid
out_ready  in  1  downstream accepts
out_pc  out  WORD_W  registered in_pc
out_nullified  out  1  instruction must not commit
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  WORD_W  redirect address, valid with redirect_valid
mispredict_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (`rst_n`=0 at edge): out_valid=0, out_pc=0, out_nullified=0, redirect_valid=0, redirect_pc=0, mispredict_cnt=0, FSM=IDLE. Reset mid-operation discards any held instruction and any pending nullify.
- Accept: a transfer occurs when `in_valid && in_ready`. Latency is 1 cycle: out_valid, out_pc and out_nullified are updated on that edge.
- Stall: when out_valid=1 and out_ready=0, all out_* hold stable. redirect_valid is never re-asserted during a stall.
- No accept and out_ready=1: out_valid drops to 0.
- Nullify FSM, states IDLE and NULL_PEND:
  - IDLE: an accepted kind=2 with cond_y=1 moves to NULL_PEND. The kind=2 instruction itself commits normally (out_nullified=0).
  - NULL_PEND: the next accepted instruction gets out_nullified=1. Its kind, cond_y and pred_taken are ignored: no redirect, no re-arm. FSM returns to IDLE.
  - NULL_PEND persists across idle/stall cycles until an instruction is accepted.
- Resolution, for a non-nullified accepted instruction:
  - kind=1: actual = cond_y. Mispredict when actual != pred_taken.
  - kind=3: mispredict when pred_taken=0.
  - kind=0 or 2: never mispredicts.
- Redirect: on the accept edge of a mispredicting instruction, redirect_valid=1 for exactly one cycle.
  - redirect_pc = in_target if taken, else in_pc+4.
  - The addition is modulo 2^WORD_W, so 0xFFFFFFFC+4 = 0x00000000.
- Flush: any instruction accepted in the cycle redirect_valid=1 is wrong-path and is dropped. out_valid is not set for it; it does not touch the FSM or the counter. A redirect also forces FSM to IDLE.
- mispredict_cnt increments by 1 on each redirect and saturates at 2^CNT_W-1, with no wrap.
- Simultaneous kind=2 (cond_y=1) and mispredict is impossible by encoding. A kind=1 arriving while in NULL_PEND is nullified, so it causes no redirect.

Test Plan:
- Reset then plain flow: rst_n=0 for 2 cycles → all outputs 0. Then kind=0, pc=0x100, out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_nullified=0, redirect_valid=0.
- Cond branch mispredict: kind=1, cond_y=1, pred_taken=0, pc=0x200, target=0x80 → redirect_valid=1 for 1 cycle, redirect_pc=0x80, mispredict_cnt=1. Instruction pc=0x204 accepted in the next cycle is dropped (out_valid=0 for it).
- Not-taken mispredict with wrap: kind=1, cond_y=0, pred_taken=1, pc=0xFFFFFFFC → redirect_pc=0x00000000. Correct prediction (cond_y=1, pred_taken=1) → no redirect, counter unchanged.
- Nullify: kind=2, cond_y=1 at pc=0x300; then kind=3, pred_taken=0 at pc=0x304 → 0x300 out_nullified=0, 0x304 out_nullified=1, no redirect. A following pc=0x308 has out_nullified=0. kind=2 with cond_y=0 → next instruction not nullified.
- Backpressure: out_ready=0 for 3 cycles after a mispredicting accept → out_pc stable, in_ready=0, redirect_valid high only in the first cycle. Release → accept resumes.
- Counter saturation and reset mid-op: force 0xFFFF redirects → mispredict_cnt stays 0xFFFF on the next redirect. Assert rst_n=0 while in NULL_PEND with out_valid=1 → out_valid=0, counter 0, next instruction not nullified.
